// File: rtl/fmap_pingpong_ram.sv
// Double-buffered feature-map store: a raster byte stream fills one bank while the other
// presents a complete frame as a flat word. Optional macro: FMAP_ZERO_ON_RELEASE_EN.
module fmap_pingpong_ram #(
    parameter int unsigned H  = 8,
    parameter int unsigned W  = 8,
    parameter int unsigned C  = 1,
    parameter int unsigned DW = 8,
    localparam int unsigned N  = H * W * C,
    localparam int unsigned AW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic            wr_flush,
    output logic [AW-1:0]   wr_ptr,
    output logic            out_valid,
    output logic            out_bank,
    output logic [N*DW-1:0] dout,
    input  logic            rd_done
);

    logic [DW-1:0] mem [2][N];
    logic [1:0]    full;
    logic [1:0]    full_nxt;
    logic          wbank;
    logic          rbank;
    logic [AW-1:0] waddr;
    logic          wr_acc;
    logic          rel;
    logic          last;

    // Status is decoded from registers only, so in_ready never depends on inputs.
    assign in_ready  = ~full[wbank];
    assign out_valid = full[rbank];
    assign out_bank  = rbank;
    assign wr_ptr    = waddr;

    assign wr_acc = in_valid & ~full[wbank] & ~wr_flush;
    assign rel    = rd_done & full[rbank];
    assign last   = (waddr == AW'(N - 1));

    // Completion and release hit different banks, so both may apply on one edge.
    always_comb begin
        full_nxt = full;
        if (wr_acc && last) full_nxt[wbank] = 1'b1;
        if (rel)            full_nxt[rbank] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full  <= 2'b00;
            wbank <= 1'b0;
            rbank <= 1'b0;
            waddr <= '0;
        end else begin
            full <= full_nxt;
            if (wr_flush) begin
                waddr <= '0;
            end else if (wr_acc) begin
                if (last) begin
                    waddr <= '0;
                    wbank <= ~wbank;
                end else begin
                    waddr <= waddr + AW'(1);
                end
            end
            if (rel) rbank <= ~rbank;
        end
    end

    // Storage array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wbank][waddr] <= in_data;
`ifdef FMAP_ZERO_ON_RELEASE_EN
        if (rel) begin
            for (int i = 0; i < int'(N); i++) mem[rbank][i] <= '0;
        end
`endif
    end

    always_comb begin
        dout = '0;
        for (int i = 0; i < int'(N); i++) dout[i*DW +: DW] = mem[rbank][i];
    end

endmodule

// File: tb/tb_fmap_pingpong_ram.sv
// Scoreboard bench for fmap_pingpong_ram: a frame-queue reference model predicts
// handshake state and frame contents; a negedge monitor compares against the DUT.
module tb_fmap_pingpong_ram;
    localparam int N  = 64;
    localparam int DW = 8;
    localparam int AW = 6;

    typedef logic [N*DW-1:0] frame_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          wr_flush = 1'b0;
    logic [AW-1:0] wr_ptr;
    logic          out_valid;
    logic          out_bank;
    frame_t        dout;
    logic          rd_done = 1'b0;

    fmap_pingpong_ram dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .wr_flush(wr_flush), .wr_ptr(wr_ptr),
        .out_valid(out_valid), .out_bank(out_bank), .dout(dout), .rd_done(rd_done)
    );

    always #5 clk = ~clk;

    // Reference model: stored complete frames in arrival order, plus the frame under fill.
    frame_t sb[$];
    frame_t cur = '0;
    int     cnt = 0;
    int     rel_cnt = 0;
    int     errors = 0;
    int     checks = 0;

    task automatic chk(input string nm, input frame_t act, input frame_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                sb.delete();
                cnt     = 0;
                rel_cnt = 0;
            end else begin
                automatic bit vld = (sb.size() > 0);
                automatic bit rdy = (sb.size() < 2);
                automatic bit acc = in_valid && rdy && !wr_flush;
                automatic bit rl  = rd_done && vld;
                if (wr_flush) begin
                    cnt = 0;
                end else if (acc) begin
                    cur[cnt*DW +: DW] = in_data;
                    if (cnt == N - 1) begin
                        sb.push_back(cur);
                        cnt = 0;
                    end else begin
                        cnt++;
                    end
                end
                if (rl) begin
                    void'(sb.pop_front());
                    rel_cnt++;
                end
            end
        end
    end

    // Monitor: compare presented state and the front frame whenever the DUT shows one.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("in_ready",  frame_t'(in_ready),  frame_t'(sb.size() < 2));
                chk("out_valid", frame_t'(out_valid), frame_t'(sb.size() > 0));
                chk("out_bank",  frame_t'(out_bank),  frame_t'(rel_cnt % 2));
                chk("wr_ptr",    frame_t'(wr_ptr),    frame_t'(cnt));
                if (out_valid && sb.size() > 0) chk("dout", dout, sb[0]);
            end
        end
    end

    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic f, input logic r);
        in_valid = v;
        in_data  = d;
        wr_flush = f;
        rd_done  = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        wr_flush = 1'b0;
        rd_done  = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] exp6;
        do_reset();
        chk("rst_in_ready",  frame_t'(in_ready),  frame_t'(1));
        chk("rst_out_valid", frame_t'(out_valid), frame_t'(0));
        chk("rst_out_bank",  frame_t'(out_bank),  frame_t'(0));
        chk("rst_wr_ptr",    frame_t'(wr_ptr),    frame_t'(0));

        // Stream 0..63 into bank0
        for (int i = 0; i < N; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        @(negedge clk);
        chk("t1_out_valid", frame_t'(out_valid), frame_t'(1));
        chk("t1_out_bank",  frame_t'(out_bank),  frame_t'(0));
        chk("t1_dout_lo",   frame_t'(dout[7:0]), frame_t'(8'h00));
        chk("t1_dout_hi",   frame_t'(dout[511:504]), frame_t'(8'h3F));
        chk("t1_wr_ptr",    frame_t'(wr_ptr),    frame_t'(0));

        // Fill bank1 without releasing, then release bank0
        for (int i = 0; i < N; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        @(negedge clk);
        chk("t2_in_ready_full", frame_t'(in_ready), frame_t'(0));
        chk("t2_out_bank_hold", frame_t'(out_bank), frame_t'(0));
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        chk("t2_out_bank", frame_t'(out_bank),  frame_t'(1));
        chk("t2_dout_lo",  frame_t'(dout[7:0]), frame_t'(8'h40));
        chk("t2_in_ready", frame_t'(in_ready),  frame_t'(1));

        // Partial frame, flush with a colliding element, then a clean frame
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
        cyc(1'b1, 8'hAA, 1'b1, 1'b0);
        @(negedge clk);
        chk("t3_wr_ptr", frame_t'(wr_ptr), frame_t'(0));
        for (int i = 0; i < N; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        chk("t3_out_bank", frame_t'(out_bank),   frame_t'(0));
        chk("t3_dout_e0",  frame_t'(dout[7:0]),  frame_t'(8'h00));
        chk("t3_dout_e1",  frame_t'(dout[15:8]), frame_t'(8'h01));

        // Both full: release and write in the same cycle
        for (int i = 0; i < N; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
        cyc(1'b1, 8'h5A, 1'b0, 1'b1);
        @(negedge clk);
        chk("t4_no_accept", frame_t'(wr_ptr),   frame_t'(0));
        chk("t4_in_ready",  frame_t'(in_ready), frame_t'(1));
        cyc(1'b1, 8'h5A, 1'b0, 1'b0);
        @(negedge clk);
        chk("t4_accept", frame_t'(wr_ptr), frame_t'(1));

        // Asynchronous reset mid-frame with bank0 full
        do_reset();
        for (int i = 0; i < N + 30; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_pre_wr_ptr", frame_t'(wr_ptr), frame_t'(30));
        #2 rst = 1'b1;
        #1;
        chk("t5_out_valid", frame_t'(out_valid), frame_t'(0));
        chk("t5_in_ready",  frame_t'(in_ready),  frame_t'(1));
        chk("t5_wr_ptr",    frame_t'(wr_ptr),    frame_t'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
        @(negedge clk);
        chk("t5_out_bank",  frame_t'(out_bank),  frame_t'(0));
        chk("t5_valid",     frame_t'(out_valid), frame_t'(1));

        // Release behaviour of bank contents
`ifdef FMAP_ZERO_ON_RELEASE_EN
        exp6 = 8'h00;
`else
        exp6 = 8'hFF;
`endif
        do_reset();
        for (int i = 0; i < N; i++) cyc(1'b1, 8'hFF, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        for (int i = 0; i < N; i++) chk("t6_mem", frame_t'(dut.mem[0][i]), frame_t'(exp6));

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) != 0, 8'($urandom),
                $urandom_range(0, 49) == 0, $urandom_range(0, 5) == 0);
        end
        in_valid = 1'b0;
        wr_flush = 1'b0;
        rd_done  = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
